simmem_addr_arbiter: RTL and testbench

// Weighted round-robin arbiter that shares the single-ported address input of

---
 rtl/simmem_addr_arbiter.sv | 141 ++++++++++++++
 tb/tb_simmem_addr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_addr_arbiter.sv
// Weighted round-robin arbiter for the calculator's shared address port.
// Gates AW/AR valid/ready only; payloads bypass this block.
module simmem_addr_arbiter #(
  parameter int unsigned WriteWeight = 2,
  parameter int unsigned ReadWeight  = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic waddr_valid_i,
  output logic waddr_ready_o,
  input  logic raddr_valid_i,
  output logic raddr_ready_o,
  output logic waddr_valid_o,
  input  logic waddr_ready_i,
  output logic raddr_valid_o,
  input  logic raddr_ready_i,
  output logic grant_w_o,
  output logic grant_r_o
);

  localparam int unsigned MaxW =
    (WriteWeight > ReadWeight) ? WriteWeight : ReadWeight;
  localparam int unsigned CW = $clog2(MaxW + 1);

  localparam logic [CW-1:0] WW_C = CW'(WriteWeight);
  localparam logic [CW-1:0] RW_C = CW'(ReadWeight);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [CW-1:0] ZERO_C = '0;

  typedef enum logic {
    OWN_W = 1'b0,
    OWN_R = 1'b1
  } owner_e;

  if (WriteWeight < 1 || ReadWeight < 1) begin : g_bad_weight
    $error("simmem_addr_arbiter: weights must be >= 1");
  end

  owner_e        owner_q, owner_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          lock_q, lock_d;
  owner_e        lock_ch_q, lock_ch_d;

  logic   gnt_w, gnt_r;
  logic   own_v, oth_v;
  logic   hs_w, hs_r, hs_any;
  logic   stall_w, stall_r;
  owner_e hs_ch;
  owner_e hs_oth;
  logic [CW-1:0] base_c;
  logic [CW-1:0] next_c;

  function automatic logic [CW-1:0] weight_of(owner_e ch);
    return (ch == OWN_W) ? WW_C : RW_C;
  endfunction

  // Owner, credit and AXI-stability lock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q   <= OWN_W;
      credit_q  <= WW_C;
      lock_q    <= 1'b0;
      lock_ch_q <= OWN_W;
    end else begin
      owner_q   <= owner_d;
      credit_q  <= credit_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Grant pick: lock first, then owner, then the idle owner's peer.
  always_comb begin
    gnt_w = 1'b0;
    gnt_r = 1'b0;
    own_v = (owner_q == OWN_W) ? waddr_valid_i : raddr_valid_i;
    oth_v = (owner_q == OWN_W) ? raddr_valid_i : waddr_valid_i;
    if (!rst_ni) begin
      gnt_w = 1'b0;
      gnt_r = 1'b0;
    end else if (lock_q) begin
      gnt_w = (lock_ch_q == OWN_W);
      gnt_r = (lock_ch_q == OWN_R);
    end else if (own_v) begin
      gnt_w = (owner_q == OWN_W);
      gnt_r = (owner_q == OWN_R);
    end else if (oth_v) begin
      gnt_w = (owner_q == OWN_R);
      gnt_r = (owner_q == OWN_W);
    end
  end

  assign hs_w    = gnt_w & waddr_valid_i & waddr_ready_i;
  assign hs_r    = gnt_r & raddr_valid_i & raddr_ready_i;
  assign hs_any  = hs_w | hs_r;
  assign stall_w = gnt_w & waddr_valid_i & ~waddr_ready_i;
  assign stall_r = gnt_r & raddr_valid_i & ~raddr_ready_i;
  assign hs_ch   = hs_r ? OWN_R : OWN_W;
  assign hs_oth  = hs_r ? OWN_W : OWN_R;

  // Credit base: running credit if owner, else a fresh turn.
  always_comb begin
    base_c = (owner_q == hs_ch) ? credit_q : weight_of(hs_ch);
    next_c = base_c - ONE_C;
  end

  // Next owner/credit on a handshake; lock tracks stalled grants.
  always_comb begin
    owner_d   = owner_q;
    credit_d  = credit_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (hs_any) begin
      lock_d = 1'b0;
      if (next_c == ZERO_C) begin
        owner_d  = hs_oth;
        credit_d = weight_of(hs_oth);
      end else begin
        owner_d  = hs_ch;
        credit_d = next_c;
      end
    end else if (stall_w) begin
      lock_d    = 1'b1;
      lock_ch_d = OWN_W;
    end else if (stall_r) begin
      lock_d    = 1'b1;
      lock_ch_d = OWN_R;
    end
  end

  // Port gating: only the granted channel sees its peer's signals.
  always_comb begin
    waddr_valid_o = gnt_w & waddr_valid_i;
    waddr_ready_o = gnt_w & waddr_ready_i;
    raddr_valid_o = gnt_r & raddr_valid_i;
    raddr_ready_o = gnt_r & raddr_ready_i;
    grant_w_o     = gnt_w;
    grant_r_o     = gnt_r;
  end

endmodule

// File: tb/tb_simmem_addr_arbiter.sv
// Bench for simmem_addr_arbiter: three weight configurations,
// vector table, corner sequences and randomized model checks.
module tb_simmem_addr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic wv[3], wr[3], rv[3], rr[3];
  logic wvo[3], wro[3], rvo[3], rro[3], gwo[3], gro[3];

  int total = 0;
  int bad = 0;

  int wgt_w[3] = '{2, 2, 1};
  int wgt_r[3] = '{2, 1, 3};

  // model: owner (0=W,1=R), handshakes served this turn, lock (-1 none)
  int m_own[3], m_srv[3], m_lck[3];
  bit m_hsw[3], m_hsr[3];

  simmem_addr_arbiter #(.WriteWeight(2), .ReadWeight(2)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .waddr_valid_i(wv[0]), .waddr_ready_o(wro[0]),
    .raddr_valid_i(rv[0]), .raddr_ready_o(rro[0]),
    .waddr_valid_o(wvo[0]), .waddr_ready_i(wr[0]),
    .raddr_valid_o(rvo[0]), .raddr_ready_i(rr[0]),
    .grant_w_o(gwo[0]), .grant_r_o(gro[0]));

  simmem_addr_arbiter #(.WriteWeight(2), .ReadWeight(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .waddr_valid_i(wv[1]), .waddr_ready_o(wro[1]),
    .raddr_valid_i(rv[1]), .raddr_ready_o(rro[1]),
    .waddr_valid_o(wvo[1]), .waddr_ready_i(wr[1]),
    .raddr_valid_o(rvo[1]), .raddr_ready_i(rr[1]),
    .grant_w_o(gwo[1]), .grant_r_o(gro[1]));

  simmem_addr_arbiter #(.WriteWeight(1), .ReadWeight(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .waddr_valid_i(wv[2]), .waddr_ready_o(wro[2]),
    .raddr_valid_i(rv[2]), .raddr_ready_o(rro[2]),
    .waddr_valid_o(wvo[2]), .waddr_ready_i(wr[2]),
    .raddr_valid_o(rvo[2]), .raddr_ready_i(rr[2]),
    .grant_w_o(gwo[2]), .grant_r_o(gro[2]));

  for (genvar k = 0; k < 3; k++) begin : g_sva
    a_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(wvo[k] && rvo[k]));
    a_wstable: assert property (@(posedge clk) disable iff (!rst_n)
      (wvo[k] && !wr[k]) |=> wvo[k]);
    a_rstable: assert property (@(posedge clk) disable iff (!rst_n)
      (rvo[k] && !rr[k]) |=> rvo[k]);
  end

  function automatic logic [5:0] outs(int k);
    return {gwo[k], gro[k], wvo[k], wro[k], rvo[k], rro[k]};
  endfunction

  task automatic chk(string nm, logic [5:0] act, logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      m_own[k] = 0;
      m_srv[k] = 0;
      m_lck[k] = -1;
      m_hsw[k] = 1'b0;
      m_hsr[k] = 1'b0;
    end
  endtask

  function automatic int mgrant(int k);
    bit vw, vr, vo, vn;
    vw = wv[k];
    vr = rv[k];
    if (!rst_n) return -1;
    if (m_lck[k] >= 0) return m_lck[k];
    vo = (m_own[k] == 0) ? vw : vr;
    vn = (m_own[k] == 0) ? vr : vw;
    if (vo) return m_own[k];
    if (vn) return 1 - m_own[k];
    return -1;
  endfunction

  task automatic mupdate(int k, int g);
    bit v, rd;
    int n, wt;
    m_hsw[k] = 1'b0;
    m_hsr[k] = 1'b0;
    if (g < 0) return;
    v  = (g == 0) ? wv[k] : rv[k];
    rd = (g == 0) ? wr[k] : rr[k];
    wt = (g == 0) ? wgt_w[k] : wgt_r[k];
    if (v && rd) begin
      if (g == 0) m_hsw[k] = 1'b1;
      else m_hsr[k] = 1'b1;
      m_lck[k] = -1;
      n = (m_own[k] == g) ? m_srv[k] + 1 : 1;
      if (n >= wt) begin
        m_own[k] = 1 - g;
        m_srv[k] = 0;
      end else begin
        m_own[k] = g;
        m_srv[k] = n;
      end
    end else if (v) begin
      m_lck[k] = g;
    end
  endtask

  // settle, compare every instance with the model, advance the model
  task automatic eval();
    int g;
    logic [5:0] e;
    #1;
    for (int k = 0; k < 3; k++) begin
      g = mgrant(k);
      e = {g == 0, g == 1,
           g == 0 && wv[k], g == 0 && wr[k],
           g == 1 && rv[k], g == 1 && rr[k]};
      chk($sformatf("model_i%0d", k), outs(k), e);
      mupdate(k, g);
    end
  endtask

  task automatic drv(int k, bit a, bit b, bit c, bit d);
    wv[k] = a;
    wr[k] = b;
    rv[k] = c;
    rr[k] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drv(k, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    mreset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit a, b, c, d;
    logic [5:0] e;
  } vec_t;

  vec_t tbl[12];
  int exp1[9] = '{1, 1, 2, 1, 1, 2, 1, 1, 2};
  int exp6[8] = '{1, 2, 2, 2, 1, 2, 2, 2};

  function automatic int gcode(int k);
    return gwo[k] ? 1 : (gro[k] ? 2 : 0);
  endfunction

  initial begin
    // e = {gw, gr, wvo, wro, rvo, rro}
    tbl[0]  = '{0, 0, 0, 0, 6'b000000};
    tbl[1]  = '{1, 1, 1, 1, 6'b101100};
    tbl[2]  = '{1, 1, 1, 1, 6'b101100};
    tbl[3]  = '{1, 1, 1, 1, 6'b010011};
    tbl[4]  = '{1, 1, 0, 0, 6'b101100};
    tbl[5]  = '{1, 0, 1, 1, 6'b101000};
    tbl[6]  = '{1, 1, 1, 1, 6'b101100};
    tbl[7]  = '{0, 0, 1, 0, 6'b010010};
    tbl[8]  = '{1, 1, 1, 0, 6'b010010};
    tbl[9]  = '{1, 1, 1, 1, 6'b010011};
    tbl[10] = '{1, 1, 1, 1, 6'b010011};
    tbl[11] = '{1, 1, 1, 1, 6'b101100};

    idle_all();
    mreset();
    #1;
    chk("reset_outs_i0", outs(0), 6'b000000);
    do_reset();

    // vector table on the 2/2 instance
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drv(0, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
      eval();
      chk($sformatf("tbl_%0d", i), outs(0), tbl[i].e);
    end

    // 2/1 pattern and 1/3 pattern, saturated
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drv(1, 1, 1, 1, 1);
      drv(2, 1, 1, 1, 1);
      eval();
      chk($sformatf("wrr21_%0d", i), 6'(gcode(1)), 6'(exp1[i]));
      if (i < 8) begin
        chk($sformatf("wrr13_%0d", i), 6'(gcode(2)), 6'(exp6[i]));
        chk($sformatf("wrr13_rdy_%0d", i),
            {4'b0, wro[2] & ~gwo[2], rro[2] & ~gro[2]}, 6'b0);
      end
    end

    // stall on W, then credit decides; plus both-valid-after-reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv(0, 1, i >= 3, 1, 1);
      drv(2, 1, i >= 3, 1, 1);
      drv(1, i == 0, 1, i == 0, 1);
      eval();
      if (i < 3) begin
        chk($sformatf("stall_i0_%0d", i), {4'b0, wvo[0], rvo[0]}, 6'b10);
        chk($sformatf("stall_i2_%0d", i), {4'b0, wvo[2], rvo[2]}, 6'b10);
      end
      if (i == 0)
        chk("first_both_w", {4'b0, gwo[1], rro[1]}, 6'b10);
      if (i == 4) begin
        chk("after_stall_ww2", 6'(gcode(0)), 6'd1);
        chk("after_stall_ww1", 6'(gcode(2)), 6'd2);
      end
    end

    // AR only: four handshakes, then owner back to W
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv(0, i == 4, 1, 1, 1);
      eval();
      chk($sformatf("ar_only_%0d", i), 6'(gcode(0)),
          (i < 4) ? 6'd2 : 6'd1);
    end

    // async reset while locked on AR
    do_reset();
    @(negedge clk);
    drv(0, 0, 0, 1, 0);
    eval();
    chk("lock_r_grant", 6'(gcode(0)), 6'd2);
    @(negedge clk);
    eval();
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("async_rst_outs", outs(0), 6'b000000);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(0, 1, 1, 1, 1);
      eval();
      chk($sformatf("post_rst_%0d", i), 6'(gcode(0)),
          (i < 2) ? 6'd1 : 6'd2);
    end

    // randomized traffic with AXI-legal valid holding
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        wv[k] = (wv[k] && !m_hsw[k]) ? 1'b1 : ($urandom_range(0, 9) < 6);
        rv[k] = (rv[k] && !m_hsr[k]) ? 1'b1 : ($urandom_range(0, 9) < 6);
        wr[k] = ($urandom_range(0, 9) < 7);
        rr[k] = ($urandom_range(0, 9) < 7);
      end
      eval();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
